// File: rtl/spi_master_driver.sv
// spi_master_driver: single-lane SPI controller engine with all four
// CPOL/CPHA modes, selectable bit order and a programmable sclk divider.
module spi_master_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic                  cfg_msb_first,
    input  logic [DIV_WIDTH-1:0]  cfg_baud_div,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi0,
    input  logic                  miso0
);

    localparam int N  = DATA_WIDTH;
    localparam int EW = $clog2(2 * N + 1);
    localparam int BW = $clog2(N + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * N);
    localparam logic [BW-1:0] ALL_BITS  = BW'(N);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_hm1;
    logic [EW-1:0]        r_edge;
    logic [BW-1:0]        r_bit;
    logic                 r_cpha;
    logic                 r_msb;
    logic [N-1:0]         r_tx;
    logic [N-1:0]         r_rx;
    logic                 r_sclk;
    logic                 r_cs;
    logic                 r_mosi;
    logic                 r_busy;
    logic                 r_ready;
    logic                 r_rx_valid;
    logic [N-1:0]         r_rx_data;

    logic [DIV_WIDTH-1:0] w_hm1;
    logic                 w_tick;
    logic [EW-1:0]        w_k;
    logic                 w_odd;
    logic                 w_last;
    logic                 w_adv;
    logic                 w_smp;
    logic                 w_tx_head;
    logic [N-1:0]         w_tx_shift;
    logic                 w_in_head;
    logic [N-1:0]         w_in_shift;
    logic [N-1:0]         w_rx_next;

    // Half-period minus one; a zero divider behaves as one.
    assign w_hm1 = (cfg_baud_div == '0) ? '0
                 : cfg_baud_div - DIV_WIDTH'(1);

    assign w_tick = (r_div == r_hm1);
    assign w_k    = r_edge + EW'(1);
    assign w_odd  = w_k[0];
    assign w_last = (r_edge == LAST_EDGE);

    assign w_adv = r_cpha ? w_odd : (!w_odd && (w_k < LAST_EDGE));
    assign w_smp = (r_cpha ? !w_odd : w_odd) && (r_bit < ALL_BITS);

    assign w_tx_head  = r_msb ? r_tx[N-1] : r_tx[0];
    assign w_tx_shift = r_msb ? {r_tx[N-2:0], 1'b0}
                              : {1'b0, r_tx[N-1:1]};

    assign w_in_head  = cfg_msb_first ? tx_data[N-1] : tx_data[0];
    assign w_in_shift = cfg_msb_first ? {tx_data[N-2:0], 1'b0}
                                      : {1'b0, tx_data[N-1:1]};

    assign w_rx_next = r_msb ? {r_rx[N-2:0], miso0}
                             : {miso0, r_rx[N-1:1]};

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_hm1      <= '0;
            r_edge     <= '0;
            r_bit      <= '0;
            r_cpha     <= 1'b0;
            r_msb      <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_sclk <= cfg_cpol;
                    if (tx_valid && r_ready) begin
                        r_state <= SETUP;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_div   <= '0;
                        r_edge  <= '0;
                        r_bit   <= '0;
                        r_hm1   <= w_hm1;
                        r_cpha  <= cfg_cpha;
                        r_msb   <= cfg_msb_first;
                        r_rx    <= '0;
                        // CPHA=0 presents bit 0 as soon as cs falls.
                        r_tx    <= cfg_cpha ? tx_data : w_in_shift;
                        r_mosi  <= cfg_cpha ? 1'b0 : w_in_head;
                    end
                end
                SETUP, SHIFT: begin
                    if (!w_tick) begin
                        r_div <= r_div + DIV_WIDTH'(1);
                    end else begin
                        r_div <= '0;
                        if (r_state == SHIFT && w_last) begin
                            r_state <= HOLD;
                        end else begin
                            r_state <= SHIFT;
                            r_edge  <= w_k;
                            r_sclk  <= ~r_sclk;
                            if (w_adv) begin
                                r_mosi <= w_tx_head;
                                r_tx   <= w_tx_shift;
                            end
                            if (w_smp) begin
                                r_rx  <= w_rx_next;
                                r_bit <= r_bit + BW'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!w_tick) begin
                        r_div <= r_div + DIV_WIDTH'(1);
                    end else begin
                        r_div      <= '0;
                        r_state    <= IDLE;
                        r_cs       <= 1'b1;
                        r_busy     <= 1'b0;
                        r_ready    <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx;
                    end
                end
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign cs       = r_cs;
    assign mosi0    = r_mosi;

endmodule

// File: tb/tb_spi_master_driver.sv
// tb_spi_master_driver: directed scenarios against a behavioural SPI
// slave; latency counts the accept cycle as cycle 1.
module tb_spi_master_driver;

    logic       pclk = 1'b0;
    logic       areset = 1'b1;
    logic       cfg_cpol = 1'b0;
    logic       cfg_cpha = 1'b0;
    logic       cfg_msb_first = 1'b1;
    logic [7:0] cfg_baud_div = 8'd1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       sclk;
    logic       cs;
    logic       mosi0;
    logic       miso0;

    int n_cmp = 0;
    int n_err = 0;
    int n_rxv = 0;

    logic       loop = 1'b0;
    logic       s_cpha = 1'b0;
    logic       s_msb = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_miso = 1'b0;
    logic [7:0] s_seq = 8'h00;
    int         s_cnt = 0;

    assign miso0 = loop ? mosi0 : s_miso;

    spi_master_driver #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
        .pclk(pclk), .areset(areset),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_msb_first(cfg_msb_first), .cfg_baud_div(cfg_baud_div),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) if (rx_valid === 1'b1) n_rxv++;

    function automatic logic s_bit(input int i);
        if (i > 7) return 1'b0;
        return s_msb ? s_data[7-i] : s_data[i];
    endfunction

    // Behavioural slave: launches miso, records mosi in arrival order.
    always @(negedge cs) begin
        s_cnt  = 0;
        s_seq  = 8'h00;
        s_miso = s_cpha ? 1'b0 : s_bit(0);
    end

    always @(sclk) begin
        if (cs === 1'b0) begin
            s_cnt++;
            if (s_cpha ? (s_cnt % 2 == 1) : (s_cnt % 2 == 0))
                s_miso = s_bit(s_cpha ? (s_cnt - 1) / 2 : s_cnt / 2);
            else
                s_seq = {s_seq[6:0], mosi0};
        end
    end

    task automatic xfer(input logic cpol, input logic cpha,
                        input logic msb, input logic [7:0] div,
                        input logic [7:0] data, output int lat);
        @(negedge pclk);
        cfg_cpol      = cpol;
        cfg_cpha      = cpha;
        cfg_msb_first = msb;
        cfg_baud_div  = div;
        tx_data       = data;
        s_cpha        = cpha;
        tx_valid      = 1'b1;
        @(posedge pclk);
        #1 tx_valid = 1'b0;
        lat = -1;
        for (int i = 2; i < 6000; i++) begin
            @(posedge pclk);
            #1;
            if (rx_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 areset = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk) areset = 1'b1;
        @(posedge pclk);
        #1;
        n_cmp++; if (cs !== 1'b1) begin n_err++;
            $display("FAIL rst_cs: got %b want 1", cs); end
        n_cmp++; if (sclk !== 1'b0) begin n_err++;
            $display("FAIL rst_sclk: got %b want 0", sclk); end
        n_cmp++; if (mosi0 !== 1'b0) begin n_err++;
            $display("FAIL rst_mosi: got %b want 0", mosi0); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++;
            $display("FAIL rst_rxv: got %b want 0", rx_valid); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++;
            $display("FAIL rst_rxd: got %h want 00", rx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++;
            $display("FAIL rst_ready: got %b want 1", tx_ready); end
    endtask

    task automatic test_mode0;
        int lat;
        loop = 1'b0; s_msb = 1'b1; s_data = 8'h3C;
        xfer(1'b0, 1'b0, 1'b1, 8'd2, 8'hA5, lat);
        n_cmp++; if (lat !== 37) begin n_err++;
            $display("FAIL m0_lat: got %0d want 37", lat); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_err++;
            $display("FAIL m0_rx: got %h want 3c", rx_data); end
        n_cmp++; if (s_seq !== 8'hA5) begin n_err++;
            $display("FAIL m0_mosi: got %h want a5", s_seq); end
        n_cmp++; if (s_cnt !== 16) begin n_err++;
            $display("FAIL m0_edges: got %0d want 16", s_cnt); end
        n_cmp++; if (tx_ready !== 1'b1 || cs !== 1'b1 || busy !== 1'b0)
            begin n_err++;
            $display("FAIL m0_done: rdy/cs/busy got %b%b%b want 110",
                     tx_ready, cs, busy); end
        @(posedge pclk);
        #1;
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++;
            $display("FAIL m0_pulse: got %b want 0", rx_valid); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_err++;
            $display("FAIL m0_hold: got %h want 3c", rx_data); end
    endtask

    task automatic test_mode3;
        int lat;
        @(negedge pclk) cfg_cpol = 1'b1;
        @(posedge pclk);
        #1;
        n_cmp++; if (sclk !== 1'b1) begin n_err++;
            $display("FAIL m3_idle: got %b want 1", sclk); end
        loop = 1'b0; s_msb = 1'b0; s_data = 8'h0F;
        xfer(1'b1, 1'b1, 1'b0, 8'd1, 8'h81, lat);
        n_cmp++; if (lat !== 19) begin n_err++;
            $display("FAIL m3_lat: got %0d want 19", lat); end
        n_cmp++; if (rx_data !== 8'h0F) begin n_err++;
            $display("FAIL m3_rx: got %h want 0f", rx_data); end
        n_cmp++; if (s_seq !== 8'h81) begin n_err++;
            $display("FAIL m3_mosi: got %h want 81", s_seq); end
        n_cmp++; if (s_cnt !== 16) begin n_err++;
            $display("FAIL m3_edges: got %0d want 16", s_cnt); end
        n_cmp++; if (sclk !== 1'b1) begin n_err++;
            $display("FAIL m3_sclk_end: got %b want 1", sclk); end
    endtask

    task automatic test_back_to_back;
        int nrx, t1, t2, cs_hi;
        logic [7:0] d1, d2;
        nrx = 0; t1 = 0; t2 = 0; cs_hi = 0; d1 = 8'h00; d2 = 8'h00;
        @(negedge pclk);
        loop = 1'b1;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_msb_first = 1'b1;
        cfg_baud_div = 8'd0;
        tx_data = 8'h96;
        tx_valid = 1'b1;
        @(posedge pclk);
        #1 tx_data = 8'h69;
        for (int i = 1; i <= 50; i++) begin
            @(posedge pclk);
            #1;
            if (rx_valid) begin
                nrx++;
                if (nrx == 1) begin t1 = i; d1 = rx_data; end
                else begin t2 = i; d2 = rx_data; end
            end
            if (nrx == 1 && cs) cs_hi++;
            if (nrx >= 1 && !cs) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        n_cmp++; if (t1 + 1 !== 19) begin n_err++;
            $display("FAIL b2b_lat1: got %0d want 19", t1 + 1); end
        n_cmp++; if (t2 - t1 !== 19) begin n_err++;
            $display("FAIL b2b_lat2: got %0d want 19", t2 - t1); end
        n_cmp++; if (nrx !== 2) begin n_err++;
            $display("FAIL b2b_pulses: got %0d want 2", nrx); end
        n_cmp++; if (cs_hi !== 1) begin n_err++;
            $display("FAIL b2b_cs_high: got %0d want 1", cs_hi); end
        n_cmp++; if (d1 !== 8'h96) begin n_err++;
            $display("FAIL b2b_rx1: got %h want 96", d1); end
        n_cmp++; if (d2 !== 8'h69) begin n_err++;
            $display("FAIL b2b_rx2: got %h want 69", d2); end
    endtask

    task automatic test_midchange;
        int lat, rdy_bad;
        lat = -1; rdy_bad = 0;
        loop = 1'b0; s_msb = 1'b1; s_data = 8'h3C; s_cpha = 1'b0;
        @(negedge pclk);
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_msb_first = 1'b1;
        cfg_baud_div = 8'd2;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(posedge pclk);
        #1 tx_valid = 1'b0;
        for (int i = 2; i < 200; i++) begin
            @(posedge pclk);
            #1;
            if (rx_valid) begin
                lat = i;
                break;
            end
            if (tx_ready) rdy_bad++;
            if (i == 5) begin
                cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_msb_first = 1'b0;
                cfg_baud_div = 8'd7; tx_data = 8'hFF;
            end
            if (i >= 5 && i <= 20) tx_valid = (i % 2 == 1);
            else tx_valid = 1'b0;
        end
        n_cmp++; if (lat !== 37) begin n_err++;
            $display("FAIL mid_lat: got %0d want 37", lat); end
        n_cmp++; if (rdy_bad !== 0) begin n_err++;
            $display("FAIL mid_ready: got %0d ready cycles want 0",
                     rdy_bad); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_err++;
            $display("FAIL mid_rx: got %h want 3c", rx_data); end
        n_cmp++; if (s_seq !== 8'hA5) begin n_err++;
            $display("FAIL mid_mosi: got %h want a5", s_seq); end
        n_cmp++; if (s_cnt !== 16) begin n_err++;
            $display("FAIL mid_edges: got %0d want 16", s_cnt); end
        @(negedge pclk);
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_msb_first = 1'b1;
        cfg_baud_div = 8'd1;
        repeat (2) @(posedge pclk);
    endtask

    task automatic test_reset_abort;
        int lat, n0;
        logic hit;
        hit = 1'b0;
        loop = 1'b0; s_msb = 1'b1; s_data = 8'h00; s_cpha = 1'b1;
        @(negedge pclk);
        cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_msb_first = 1'b1;
        cfg_baud_div = 8'd2;
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        @(posedge pclk);
        #1 tx_valid = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge pclk);
            #1;
            if (s_cnt == 5 && cs === 1'b0) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++; if (hit !== 1'b1) begin n_err++;
            $display("FAIL abort_edge5: got %b want 1", hit); end
        n0 = n_rxv;
        areset = 1'b0;
        #1;
        n_cmp++; if (cs !== 1'b1 || sclk !== 1'b0 || mosi0 !== 1'b0)
            begin n_err++;
            $display("FAIL abort_pins: cs/sclk/mosi got %b%b%b want 100",
                     cs, sclk, mosi0); end
        n_cmp++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin n_err++;
            $display("FAIL abort_ctl: busy/rdy got %b%b want 01",
                     busy, tx_ready); end
        repeat (3) @(posedge pclk);
        @(negedge pclk) areset = 1'b1;
        repeat (40) @(posedge pclk);
        n_cmp++; if (n_rxv !== n0) begin n_err++;
            $display("FAIL abort_rxv: got %0d pulses want 0", n_rxv - n0);
        end
        loop = 1'b1;
        xfer(1'b0, 1'b1, 1'b1, 8'd2, 8'h5A, lat);
        n_cmp++; if (rx_data !== 8'h5A) begin n_err++;
            $display("FAIL abort_next_rx: got %h want 5a", rx_data); end
        n_cmp++; if (lat !== 37) begin n_err++;
            $display("FAIL abort_next_lat: got %0d want 37", lat); end
    endtask

    task automatic test_loop_modes;
        int lat;
        loop = 1'b1;
        xfer(1'b0, 1'b1, 1'b1, 8'd3, 8'hC3, lat);
        n_cmp++; if (rx_data !== 8'hC3 || lat !== 55) begin n_err++;
            $display("FAIL lb_m1_msb: rx %h lat %0d want c3 55",
                     rx_data, lat); end
        xfer(1'b0, 1'b1, 1'b0, 8'd1, 8'hC3, lat);
        n_cmp++; if (rx_data !== 8'hC3 || lat !== 19) begin n_err++;
            $display("FAIL lb_m1_lsb: rx %h lat %0d want c3 19",
                     rx_data, lat); end
        xfer(1'b1, 1'b0, 1'b1, 8'd1, 8'hC3, lat);
        n_cmp++; if (rx_data !== 8'hC3 || lat !== 19) begin n_err++;
            $display("FAIL lb_m2_msb: rx %h lat %0d want c3 19",
                     rx_data, lat); end
        xfer(1'b1, 1'b0, 1'b0, 8'd2, 8'hC3, lat);
        n_cmp++; if (rx_data !== 8'hC3 || lat !== 37) begin n_err++;
            $display("FAIL lb_m2_lsb: rx %h lat %0d want c3 37",
                     rx_data, lat); end
    endtask

    task automatic test_max_div;
        int lat;
        loop = 1'b1;
        xfer(1'b0, 1'b0, 1'b0, 8'd255, 8'h4D, lat);
        n_cmp++; if (lat !== 4591) begin n_err++;
            $display("FAIL maxdiv_lat: got %0d want 4591", lat); end
        n_cmp++; if (rx_data !== 8'h4D) begin n_err++;
            $display("FAIL maxdiv_rx: got %h want 4d", rx_data); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_midchange();
        test_reset_abort();
        test_loop_modes();
        test_max_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_driver.md
Name: spi_master_driver

Overview:
Synthesizable SPI master (controller) engine for the SPI AVIP. It generates sclk and cs, serializes a parallel word onto mosi0 and deserializes miso0 into a parallel word. It is the initiator-side counterpart of the slave driver BFM and can drive that BFM or an SPI slave RTL in hdl_top. It supports all four CPOL/CPHA modes, MSB- or LSB-first ordering and a programmable clock divider, on single-lane (mosi0/miso0) transfers.

Parameters:
DATA_WIDTH, 8, bits per transfer (legal range 2..32)
DIV_WIDTH, 8, width of cfg_baud_div

Ports:
pclk  input  1  system clock; all logic on rising edge
areset  input  1  asynchronous active-low reset
cfg_cpol  input  1  sclk idle level
cfg_cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge
cfg_msb_first  input  1  1 = MSB shifted first, 0 = LSB first
cfg_baud_div  input  DIV_WIDTH  sclk half-period in pclk cycles; 0 treated as 1
tx_valid  input  1  request to start a transfer
tx_ready  output  1  engine idle, can accept a request
tx_data  input  DATA_WIDTH  word to send on mosi0
rx_valid  output  1  one-cycle pulse, rx_data valid
rx_data  output  DATA_WIDTH  word captured from miso0
busy  output  1  transfer in progress (cs low)
sclk  output  1  SPI serial clock
cs  output  1  chip select, active low
mosi0  output  1  serial data to slave
miso0  input  1  serial data from slave

Behaviour:
- Reset (async assert, sync deassert by user): state=IDLE, cs=1, sclk=0, mosi0=0, rx_valid=0, rx_data=0, busy=0, tx_ready=1; bit/edge/divider counters=0. Assertion mid-transfer aborts immediately, and no rx_valid is produced.
- Let H = max(cfg_baud_div,1) and N = DATA_WIDTH.
- All cfg_* inputs and tx_data are latched at accept (tx_valid && tx_ready). Changes during a transfer are ignored.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - tx_ready=1, cs=1, busy=0.
  - sclk is registered from cfg_cpol each cycle.
  - On accept: next cycle cs=0, busy=1, tx_ready=0, enter SETUP.
  - tx_valid is ignored whenever tx_ready=0.
- SETUP:
  - Lasts H cycles; sclk=CPOL.
  - CPHA=0: the first data bit is on mosi0 from the cycle cs falls.
  - CPHA=1: mosi0 holds 0 until the first edge.
- SHIFT:
  - 2N sclk edges, numbered 1..2N, one every H cycles.
  - Edge 1 occurs H cycles after SETUP entry; sclk toggles on each edge.
  - CPHA=0: miso0 is sampled on odd edges; mosi0 advances to the next bit on even edges 2..2N-2.
  - CPHA=1: mosi0 advances (first bit on edge 1) on odd edges; miso0 is sampled on even edges.
  - Sampling captures miso0 at the same pclk edge that updates the sclk register.
  - Bit order follows the latched msb_first for both TX and RX (the first sampled bit lands in bit N-1 if MSB-first, else bit 0).
- HOLD:
  - Entered after edge 2N; sclk=CPOL (already there after an even number of toggles), cs stays 0.
  - mosi0 holds the last bit; lasts H cycles.
  - Then cs=1, busy=0, and the state returns to IDLE.
- Completion:
  - In the first IDLE cycle after HOLD, rx_valid=1 for exactly one cycle and rx_data is updated.
  - rx_data holds its value until the next completion.
- Latency: accept edge to rx_valid high = (2N+2)*H + 1 pclk cycles.
- Back-to-back: tx_ready is 1 in the rx_valid cycle. The minimum cs-high time between transfers is 1 pclk.
- The divider counter width is DIV_WIDTH. There is no overflow at max div (H = 2^DIV_WIDTH-1).
- The bit counter saturates at N, and no extra edges are generated.

Test Plan:
- Mode 0 (cpol=0, cpha=0), MSB-first, div=2, tx_data=0xA5, slave model returns 0x3C -> mosi0 sequence 1,0,1,0,0,1,0,1; 16 sclk edges starting low; rx_data=0x3C; rx_valid 37 cycles after accept.
- Mode 3 (cpol=1, cpha=1), LSB-first, div=1, tx_data=0x81, miso0 returns 0x0F -> sclk idles high; mosi0 bits 1,0,0,0,0,0,0,1 launched on odd edges; rx_data=0x0F; latency 19 cycles.
- cfg_baud_div=0 -> identical timing to div=1; hold tx_valid=1 continuously -> two back-to-back transfers with cs high exactly 1 cycle between them, and two rx_valid pulses.
- Change cfg_cpol/cfg_msb_first and toggle tx_valid mid-transfer -> no effect on the current transfer; tx_ready stays 0 until completion.
- Assert areset at edge 5 of a mode-1 transfer -> cs=1, sclk=0, mosi0=0 immediately; no rx_valid; the next transfer after release completes correctly with 0x5A loopback.
- Modes 1 and 2 with mosi0 looped to miso0, tx_data=0xC3 -> rx_data=0xC3 in both orders.
